count_seq_checker: RTL and testbench

//  Downstream monitor for the free-running 4-bit up counter. Samples its count

---
 rtl/count_seq_checker_pkg.sv | 21 ++
 rtl/count_seq_checker_if.sv | 15 +
 rtl/count_seq_checker_cap_fifo.sv | 53 +++++
 rtl/count_seq_checker.sv | 125 ++++++++++++
 tb/tb_count_seq_checker.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for the count sequence checker: FSM state encoding
// and default widths/depth used by the checker, its FIFO and benches.
package count_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam int CNT_W_DEF      = 4;
    localparam int WRAP_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // Width of one captured timestamp {wrap_cnt, count}.
    function automatic int cap_width(input int cnt_w, input int wrap_w);
        return cnt_w + wrap_w;
    endfunction

endpackage

// File: rtl/count_seq_checker_if.sv
// Capture stream carrying timestamps out of the checker (valid/ready).
interface count_seq_checker_if
    import count_seq_checker_pkg::*;
#(
    parameter int W = cap_width(CNT_W_DEF, WRAP_W_DEF)
) ();

    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/count_seq_checker_cap_fifo.sv
// Small first-word-fall-through FIFO. The head entry is always visible on
// dout; a write is taken when not full, or when full and popping the same
// edge (the freed head slot is exactly the slot the write pointer targets).
module cap_fifo
    import count_seq_checker_pkg::*;
#(
    parameter int W     = cap_width(CNT_W_DEF, WRAP_W_DEF),
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update and storage write; storage cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a free-running up counter: checks each sample is previous+1,
// counts wrap-arounds, flags sequence errors and captures {wrap_cnt, count}
// timestamps on trigger into a FWFT FIFO presented on a valid/ready stream.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WRAP_W     = WRAP_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              trig,
    input  logic              err_clr,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic              cap_drop,
    count_seq_checker_if.master cap
);

    localparam int CW = CNT_W + WRAP_W;

    state_t            state;
    logic [CNT_W-1:0]  prev;
    logic [CNT_W-1:0]  exp_cnt;
    logic              seq_ok;
    logic              at_max;
    logic              tracking;
    logic              wrap_hit;
    logic [WRAP_W-1:0] wrap_nxt;
    logic              cap_req;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop_req;
    logic [CW-1:0]     fifo_din;
    logic [CW-1:0]     fifo_dout;

    // Sequence compare, wrap detection and capture request for this edge.
    always_comb begin
        exp_cnt  = prev + 1'b1;
        seq_ok   = (count_in == exp_cnt);
        at_max   = &prev;
        tracking = en && (state == ST_TRACK);
        wrap_hit = tracking && seq_ok && at_max;
        wrap_nxt = wrap_cnt + {{(WRAP_W-1){1'b0}}, wrap_hit};
        // A trig on an erroring edge is not captured.
        cap_req  = tracking && seq_ok && trig;
        fifo_pop = cap.valid && cap.ready;
        drop_req = cap_req && fifo_full && !fifo_pop;
        fifo_din = {wrap_nxt, count_in};
    end

    assign cap.valid = !fifo_empty;
    assign cap.data  = fifo_dout;

    cap_fifo #(
        .W     (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_cap_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_req),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // Checker FSM with its tracking registers and registered pulse/flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            prev       <= '0;
            wrap_cnt   <= '0;
            wrap_pulse <= 1'b0;
            err        <= 1'b0;
            cap_drop   <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            cap_drop   <= drop_req;
            if (!en) begin
                // Disable wins over everything; wrap_cnt and FIFO contents are kept.
                state <= ST_IDLE;
                err   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        prev     <= count_in;
                        wrap_cnt <= '0;
                        state    <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (seq_ok) begin
                            prev       <= count_in;
                            wrap_cnt   <= wrap_nxt;
                            wrap_pulse <= at_max;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                    ST_ERR: begin
                        if (err_clr) begin
                            state <= ST_SYNC;
                            err   <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        err   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios followed by randomized
// traffic, all checked against a behavioural model through a scoreboard.
module tb_count_seq_checker;
    import count_seq_checker_pkg::*;

    localparam int DW    = 12;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [3:0] count_in = '0;
    logic       trig = 1'b0;
    logic       err_clr = 1'b0;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;
    logic       err;
    logic       cap_drop;

    count_seq_checker_if #(.W(DW)) cap_if ();

    count_seq_checker #(
        .CNT_W      (4),
        .WRAP_W     (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .count_in   (count_in),
        .trig       (trig),
        .err_clr    (err_clr),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .err        (err),
        .cap_drop   (cap_drop),
        .cap        (cap_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit pulse;
        int wraps;
        bit err;
        bit drop;
        bit valid;
    } out_t;

    bit          m_active;   // enabled for at least one edge since leaving idle
    bit          m_synced;   // a reference sample has been taken
    bit          m_err;
    int          m_prev;
    int          m_wraps;
    logic [11:0] m_fifo[$];

    out_t        exp_out[$];
    logic [11:0] exp_cap[$];
    bit          mon_on = 1'b0;

    function automatic void model_reset();
        m_active = 1'b0;
        m_synced = 1'b0;
        m_err    = 1'b0;
        m_prev   = 0;
        m_wraps  = 0;
        m_fifo.delete();
        exp_out.delete();
        exp_cap.delete();
    endfunction

    function automatic void model_step();
        out_t        o;
        int          c;
        bit          pop;
        bit          want;
        logic [11:0] entry;
        c     = int'(count_in);
        pop   = (m_fifo.size() > 0) && cap_if.ready;
        want  = 1'b0;
        entry = '0;
        o.pulse = 1'b0;
        o.drop  = 1'b0;
        if (!en) begin
            m_active = 1'b0;
            m_synced = 1'b0;
            m_err    = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_synced = 1'b0;
        end else if (m_err) begin
            if (err_clr) begin
                m_err    = 1'b0;
                m_synced = 1'b0;
            end
        end else if (!m_synced) begin
            m_prev   = c;
            m_wraps  = 0;
            m_synced = 1'b1;
        end else if (c == (m_prev + 1) % 16) begin
            if (m_prev == 15) begin
                m_wraps = (m_wraps + 1) % 256;
                o.pulse = 1'b1;
            end
            m_prev = c;
            if (trig) begin
                want  = 1'b1;
                entry = 12'(m_wraps * 16 + c);
            end
        end else begin
            m_err = 1'b1;
        end
        if (want && !(m_fifo.size() < DEPTH || pop)) o.drop = 1'b1;
        if (pop) void'(m_fifo.pop_front());
        if (want && !o.drop) begin
            m_fifo.push_back(entry);
            exp_cap.push_back(entry);
        end
        o.wraps = m_wraps;
        o.err   = m_err;
        o.valid = (m_fifo.size() != 0);
        exp_out.push_back(o);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        out_t o;
        if (mon_on && rst_n && exp_out.size() > 0) begin
            o = exp_out.pop_front();
            chk("wrap_pulse", int'(wrap_pulse), int'(o.pulse));
            chk("wrap_cnt",   int'(wrap_cnt),   o.wraps);
            chk("err",        int'(err),        int'(o.err));
            chk("cap_drop",   int'(cap_drop),   int'(o.drop));
            chk("cap_valid",  int'(cap_if.valid), int'(o.valid));
            if (cap_if.valid) begin
                if (exp_cap.size() == 0) begin
                    chk("cap_unexpected", 1, 0);
                end else begin
                    chk("cap_data", int'(cap_if.data), int'(exp_cap[0]));
                    if (cap_if.ready) void'(exp_cap.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit e, input int c, input bit tr, input bit cl, input bit rdy);
        en           = e;
        count_in     = 4'(c);
        trig         = tr;
        err_clr      = cl;
        cap_if.ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_cap_valid",  int'(cap_if.valid), 0);
        chk("rst_err",        int'(err),          0);
        chk("rst_wrap_cnt",   int'(wrap_cnt),     0);
        chk("rst_wrap_pulse", int'(wrap_pulse),   0);
        chk("rst_cap_drop",   int'(cap_drop),     0);
        model_reset();
        en           = 1'b0;
        trig         = 1'b0;
        err_clr      = 1'b0;
        cap_if.ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int cnt;
    int pulses;

    initial begin
        cap_if.ready = 1'b0;
        #2;
        do_reset();
        mon_on = 1'b1;

        // Free-running count from 0 for 40 samples.
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1, i, 0, 0, 1);
            if (wrap_pulse) pulses++;
        end
        chk("t1_wrap_cnt", int'(wrap_cnt), 2);
        chk("t1_pulses",   pulses, 2);
        chk("t1_err",      int'(err), 0);

        // Skip 5->7 while tracking, then recover with err_clr.
        for (int i = 40; i <= 53; i++) tick(1, i, 0, 0, 1);
        tick(1, 7, 0, 0, 1);
        chk("t2_err_set",    int'(err), 1);
        chk("t2_wrap_frozen", int'(wrap_cnt), 3);
        tick(1, 8, 1, 0, 1);
        chk("t2_err_hold",   int'(err), 1);
        chk("t2_wrap_hold",  int'(wrap_cnt), 3);
        chk("t2_no_cap",     int'(cap_if.valid), 0);
        tick(1, 9, 0, 1, 1);
        chk("t2_err_clr",    int'(err), 0);
        tick(1, 10, 0, 0, 1);
        tick(1, 11, 0, 0, 1);
        tick(1, 12, 0, 0, 1);
        chk("t2_resume_err",  int'(err), 0);
        chk("t2_resume_wrap", int'(wrap_cnt), 0);

        // Single capture at count 9 with one wrap seen.
        do_reset();
        for (int i = 0; i <= 25; i++) tick(1, i, (i == 25), 0, 1);
        chk("t3_valid", int'(cap_if.valid), 1);
        chk("t3_data",  int'(cap_if.data), 12'h019);
        tick(1, 26, 0, 0, 1);
        chk("t3_popped", int'(cap_if.valid), 0);

        // Five triggers with a stalled consumer: fifth one is dropped.
        cnt = 27;
        for (int k = 0; k < 5; k++) begin
            tick(1, cnt, 1, 0, 0);
            cnt++;
            if (k < 4) chk("t4_no_drop", int'(cap_drop), 0);
            else       chk("t4_drop",    int'(cap_drop), 1);
        end
        tick(1, cnt, 0, 0, 0); cnt++;
        chk("t4_drop_pulse", int'(cap_drop), 0);
        for (int k = 0; k < 4; k++) begin
            tick(1, cnt, 0, 0, 1); cnt++;
        end
        chk("t4_drained", int'(cap_if.valid), 0);

        // Full FIFO with a simultaneous pop and push.
        for (int k = 0; k < 4; k++) begin
            tick(1, cnt, 1, 0, 0); cnt++;
        end
        tick(1, cnt, 1, 0, 1); cnt++;
        chk("t5_no_drop", int'(cap_drop), 0);
        chk("t5_valid",   int'(cap_if.valid), 1);
        tick(1, cnt, 1, 0, 0); cnt++;
        chk("t5_still_full", int'(cap_drop), 1);
        for (int k = 0; k < 4; k++) begin
            tick(1, cnt, 0, 0, 1); cnt++;
        end
        chk("t5_drained", int'(cap_if.valid), 0);

        // Reset mid-track with entries queued.
        for (int k = 0; k < 20; k++) begin
            tick(1, cnt, 0, 0, 0); cnt++;
        end
        tick(1, cnt, 1, 0, 0); cnt++;
        tick(1, cnt, 1, 0, 0); cnt++;
        chk("t6_queued", int'(cap_if.valid), 1);
        do_reset();
        tick(0, 4, 0, 0, 0);
        tick(1, 3, 0, 0, 0);
        tick(1, 9, 0, 0, 0);
        chk("t6_idle_sync", int'(err), 0);
        tick(1, 10, 0, 0, 0);
        chk("t6_track", int'(err), 0);

        // Randomized traffic.
        cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            tick(($urandom_range(0, 49) != 0), cnt, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
            if (r < 3)      cnt += 2;
            else if (r < 5) cnt += 0;
            else            cnt += 1;
            if ($urandom_range(0, 699) == 0) do_reset();
        end

        tick(1, cnt, 0, 0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", exp_out.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
